// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, status word layout
// and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int RX_FULL_BIT           = 8;
  localparam int RX_FERR_BIT           = 9;
  localparam int RX_OVR_BIT            = 10;
  localparam int BIT_CYCLES_115200_50M = 434;

  // Packs the receive buffer into the CPU-visible status/data word.
  function automatic logic [31:0] rx_status(input logic [7:0] data,
                                            input logic       full,
                                            input logic       ferr,
                                            input logic       ovr);
    logic [31:0] word;
    word              = 32'h0000_0000;
    word[7:0]         = data;
    word[RX_FULL_BIT] = full;
    word[RX_FERR_BIT] = ferr;
    word[RX_OVR_BIT]  = ovr;
    return word;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous input; all stages reset to
// RESET_VAL so an idle-high line does not look active after reset.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_r;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_r <= {STAGES{RESET_VAL}};
    end else begin
      stage_r <= {stage_r[STAGES-2:0], d};
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Bus-attached 8N1 UART receiver: oversampled mid-bit sampling, a single-byte
// receive buffer with status flags, and a one-cycle-latency read port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES  = BIT_CYCLES_115200_50M,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam int            TW        = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] HALF_LAST = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYCLES - 1);

  rx_state_e     state_r, state_nx_s;
  logic [TW-1:0] timer_r, timer_nx_s;
  logic [2:0]    bit_r, bit_nx_s;
  logic [7:0]    shifter_r, shifter_nx_s;
  logic [7:0]    data_r;
  logic          full_r, ferr_r, ovr_r, rdy_r;
  logic [31:0]   rdata_r;
  logic          rx_s, commit_s, accept_s, read_s;
  logic          unused_s;

  assign unused_s = ^{mem_instr, mem_wdata, mem_addr};

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serialIn),
    .q     (rx_s)
  );

  // Receive FSM state and bit-timing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      bit_r     <= 3'd0;
      shifter_r <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      timer_r   <= timer_nx_s;
      bit_r     <= bit_nx_s;
      shifter_r <= shifter_nx_s;
    end
  end

  // Next-state logic; the start bit is re-checked at mid-bit to reject glitches.
  always_comb begin
    state_nx_s   = state_r;
    timer_nx_s   = timer_r + 1'b1;
    bit_nx_s     = bit_r;
    shifter_nx_s = shifter_r;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        timer_nx_s = '0;
        if (!rx_s) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        if (timer_r == HALF_LAST) begin
          timer_nx_s = '0;
          bit_nx_s   = 3'd0;
          state_nx_s = rx_s ? IDLE : DATA;
        end else begin
          state_nx_s = START;
        end
      end
      DATA: begin
        if (timer_r == BIT_LAST) begin
          timer_nx_s   = '0;
          shifter_nx_s = {rx_s, shifter_r[7:1]};
          bit_nx_s     = bit_r + 3'd1;
          state_nx_s   = (bit_r == 3'd7) ? STOP : DATA;
        end else begin
          state_nx_s = DATA;
        end
      end
      STOP: begin
        if (timer_r == BIT_LAST) begin
          timer_nx_s = '0;
          commit_s   = 1'b1;
          state_nx_s = rx_s ? IDLE : BREAK;
        end else begin
          state_nx_s = STOP;
        end
      end
      BREAK: begin
        timer_nx_s = '0;
        state_nx_s = rx_s ? IDLE : BREAK;
      end
      default: begin
        timer_nx_s = '0;
        state_nx_s = IDLE;
      end
    endcase
  end

  assign accept_s = mem_valid & enable & ~rdy_r;
  assign read_s   = accept_s & (mem_wstrb == 4'b0000);

  // Receive buffer; a read on the commit cycle consumes the old byte, so no overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= 8'h00;
      full_r <= 1'b0;
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else if (commit_s) begin
      data_r <= shifter_r;
      full_r <= 1'b1;
      ferr_r <= ~rx_s;
      ovr_r  <= ~read_s & (ovr_r | full_r);
    end else if (read_s) begin
      full_r <= 1'b0;
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;
    end
  end

  // Bus acknowledge and read data, latched at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      rdy_r <= accept_s;
      if (accept_s) begin
        rdata_r <= rx_status(data_r, full_r, ferr_r, ovr_r);
      end
    end
  end

  assign mem_ready = enable ? rdy_r : 1'bz;
  assign mem_rdata = enable ? rdata_r : {32{1'bz}};

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 16 clocks per bit, checked
// against a byte-level model of the receive buffer.
module tb_uart_rx;

  localparam int BITC = 16;

  logic        clk = 1'b0;
  logic        reset, enable, mem_valid, mem_instr, serialIn;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr;
  wire         mem_ready;
  wire  [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the buffer: last byte plus its flags.
  logic [7:0] m_data;
  logic       m_full, m_ferr, m_ovr;

  uart_rx #(.BIT_CYCLES(BITC), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .serialIn  (serialIn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    return {21'd0, m_ovr, m_ferr, m_full, m_data};
  endfunction

  task automatic m_reset();
    m_data = 8'h00; m_full = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic m_commit(input logic [7:0] b, input logic stop);
    m_ovr  = m_ovr | m_full;
    m_data = b;
    m_full = 1'b1;
    m_ferr = ~stop;
  endtask

  function automatic logic [31:0] m_take_read();
    logic [31:0] w;
    w = m_word();
    m_full = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    return w;
  endfunction

  // Call right after a falling edge; drives start, 8 data bits LSB first, stop.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serialIn = bits[i];
      repeat (BITC) @(negedge clk);
    end
  endtask

  task automatic bus(input logic wr, output logic [31:0] word);
    @(negedge clk);
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_wstrb = wr ? 4'hF : 4'h0;
    mem_wdata = $urandom;
    mem_addr  = $urandom;
    @(posedge clk);
    #1;
    chk("ready_ack", {31'd0, mem_ready}, 32'd1);
    word = mem_rdata;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    chk("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
  endtask

  task automatic read_expect(input string tag);
    logic [31:0] w;
    bus(1'b0, w);
    chk(tag, w, m_take_read());
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    logic        stop, rd_ok;

    reset = 1'b1; enable = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_wstrb = 4'h0; mem_wdata = 32'h0; mem_addr = 32'h0; serialIn = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, mem_ready}, 32'd0);
    read_expect("reset_status");

    // Clean byte, a write (no side effect), then two reads.
    @(negedge clk);
    send_frame(8'hA5, 1'b1);
    m_commit(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    bus(1'b1, w);
    chk("write_status", w, m_word());
    read_expect("a5_first");
    read_expect("a5_second");

    // Short low glitch while idle must not produce a byte.
    @(negedge clk);
    serialIn = 1'b0;
    repeat (4) @(negedge clk);
    serialIn = 1'b1;
    repeat (40) @(negedge clk);
    read_expect("glitch");

    // Two bytes without a read in between.
    @(negedge clk);
    send_frame(8'h11, 1'b1);
    m_commit(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    m_commit(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    read_expect("overrun_first");
    read_expect("overrun_second");

    // Framing error followed by a held-low line.
    @(negedge clk);
    send_frame(8'h3C, 1'b0);
    m_commit(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    serialIn = 1'b1;
    repeat (200) @(negedge clk);
    read_expect("break_first");
    read_expect("break_second");

    // Read accepted on the same cycle the 0x7E stop bit commits.
    @(negedge clk);
    send_frame(8'h55, 1'b1);
    m_commit(8'h55, 1'b1);
    @(negedge clk);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (154) @(posedge clk);
        bus(1'b0, w);
      end
    join
    chk("collide_old", w, m_take_read());
    m_commit(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    read_expect("collide_new");

    // Random bytes and stop bits with occasional reads.
    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom_range(255, 0));
      stop = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      send_frame(b, stop);
      m_commit(b, stop);
      if (!stop) begin
        repeat (20) @(negedge clk);
        serialIn = 1'b1;
        repeat (20) @(negedge clk);
      end
      if ($urandom_range(1, 0) == 1) begin
        read_expect("rand_read");
      end
    end
    read_expect("rand_final");

    // Reset in the middle of 0xFF data bits, then a clean 0x0F.
    @(negedge clk);
    serialIn = 1'b0;
    repeat (BITC) @(negedge clk);
    serialIn = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    repeat (12 * BITC) @(negedge clk);
    send_frame(8'h0F, 1'b1);
    m_commit(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    read_expect("after_reset");

    // Deselect during the acknowledge cycle: outputs must release the bus.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    enable = 1'b0;
    #1;
    chk("ready_released", {31'd0, (mem_ready === 1'b1)}, 32'd0);
    rd_ok = (mem_rdata === 32'hz) || (mem_rdata === 32'h0);
    chk("rdata_released", {31'd0, rd_ok}, 32'd1);
    w = m_take_read();
    @(negedge clk);
    mem_valid = 1'b0;
    enable    = 1'b1;
    #1;
    chk("rdata_reselect", mem_rdata, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Memory-mapped UART receiver, 8N1, the receive counterpart of the team's bus-attached UART transmitter.
- Oversamples the asynchronous serial input and samples each bit at mid-bit.
- Holds one received byte plus status flags in a single-byte buffer; the CPU reads it over the native valid/ready memory bus.
- Shares the bus with other peripherals; outputs are tri-stated when not selected.

Parameters:
- BIT_CYCLES, 434, clk cycles per bit (115200 baud at 50 MHz); must be >= 8.
- SYNC_STAGES, 2, flip-flops in the serialIn synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  address-decode select for this peripheral.
- mem_valid  in  1  bus request.
- mem_ready  out  1  bus acknowledge; 'z' when enable=0.
- mem_instr  in  1  unused.
- mem_wstrb  in  4  write strobes; any nonzero value marks a write.
- mem_wdata  in  32  unused (writes are acknowledged and ignored).
- mem_addr  in  32  unused (single register).
- mem_rdata  out  32  status/data word; 'z' when enable=0.
- serialIn  in  1  asynchronous serial line; idles high.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, all counters 0, data=0, full=0, frame_err=0, overrun=0, rdy=0.
  - Synchronizer flops are preset to 1.
  - Reset mid-frame aborts the frame and discards partial data.
- Line input: rx = serialIn after SYNC_STAGES flops. All decisions use rx only.
- Receive FSM:
  - IDLE: when rx=0, go to START with timer=0.
  - START:
    - At timer=BIT_CYCLES/2-1, if rx=0, go to DATA with timer=0 and bit=0.
    - Otherwise the start was a glitch; return to IDLE.
  - DATA:
    - At timer=BIT_CYCLES-1, shift rx into shifter[7] with a right shift (LSB first) and reset timer.
    - After bit=7, go to STOP.
  - STOP: at timer=BIT_CYCLES-1, sample rx.
    - Commit: data<=shifter, full<=1, frame_err<=~rx, overrun<=overrun|full. A new byte always overwrites the buffer.
    - If rx=1, go to IDLE.
    - If rx=0 (break or framing error), go to BREAK.
  - BREAK: stay until rx=1, then go to IDLE. This prevents a held-low line from retriggering.
- Bus access:
  - An access is accepted on a cycle with mem_valid & enable & ~rdy.
  - rdy (mem_ready) is high in the next cycle only, for exactly one cycle. Read latency = 1.
  - mem_rdata is latched at acceptance:
    - [7:0] data
    - [8] full
    - [9] frame_err
    - [10] overrun
    - [31:11] 0
  - Read (mem_wstrb=0): at acceptance, clear full, frame_err and overrun.
  - Write (mem_wstrb≠0): acknowledged, no side effect.
- Simultaneous read acceptance and STOP commit:
  - The read returns the old byte and flags.
  - The new byte is stored with full=1 and frame_err from its own stop bit.
  - overrun=0, because the old byte was consumed.
- Timer is $clog2(BIT_CYCLES) bits wide and wraps only through an explicit reset to 0; no free-running wrap.

Decomposition:
- Package uart_pkg:
  - FSM state enum IDLE/START/DATA/STOP/BREAK.
  - Status bit positions: RX_FULL_BIT=8, RX_FERR_BIT=9, RX_OVR_BIT=10.
  - Default BIT_CYCLES_115200_50M=434.
- One natural sub-module: sync_ff (parameterized multi-stage synchronizer with reset value 1), reusable by other async inputs.
- The FSM, buffer and bus logic stay in uart_rx.

Test Plan:
- Run with BIT_CYCLES=16.
- Byte 0xA5 sent 8N1 (start, LSB first, stop=1), then bus read:
  - rdata=0x000001A5, mem_ready high exactly 1 cycle after acceptance.
  - A second read returns 0x000000A5 (full cleared).
- 4-cycle low glitch on serialIn while idle:
  - FSM returns to IDLE, no byte is stored.
  - A subsequent read shows bit8=0.
- Bytes 0x11 then 0x22 received without an intervening read:
  - Read returns 0x00000522 (full and overrun set).
  - Next read returns 0x00000022.
- Byte 0x3C with stop bit=0, then line held low 40 cycles, then high:
  - Read returns 0x0000033C.
  - No further byte is received while low (stays in BREAK).
- Read accepted on the exact cycle a 0x7E stop commits while 0x55 is buffered:
  - Read returns 0x00000155.
  - Next read returns 0x0000017E, overrun=0.
- reset asserted midway through the data bits of 0xFF, then a clean 0x0F:
  - First read returns 0x0000010F (partial frame discarded).
  - With enable=0, mem_ready and mem_rdata are 'z'.
